// File: rtl/frame_reception_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_reception_pkg
// Brief   : Shared state encodings, framing constants and field lengths for
//           the Ethernet byte-stream receive path.
// Revision: 1.0  initial release
// ============================================================================
package frame_reception_pkg;

  // Encodings match the transmit side so debug state values line up
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PREAMBLE = 4'd1,
    ST_DEST     = 4'd2,
    ST_SRC      = 4'd3,
    ST_TYPE     = 4'd4,
    ST_PAYLOAD  = 4'd5,
    ST_FCS      = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERROR    = 4'd8,
    ST_DRAIN    = 4'd9
  } rx_state_t;

  localparam logic [7:0]  c_eth_preamble = 8'h55;
  localparam logic [7:0]  c_eth_sfd      = 8'hD5;
  localparam logic [31:0] c_crc32_poly   = 32'hEDB88320;
  localparam logic [31:0] c_crc32_init   = 32'hFFFFFFFF;
  localparam logic [47:0] c_bcast_addr   = 48'hFFFFFFFFFFFF;

  localparam int c_dest_bytes = 6;
  localparam int c_src_bytes  = 6;
  localparam int c_type_bytes = 2;
  localparam int c_fcs_bytes  = 4;

  localparam logic [2:0] c_cnt_max = 3'd7;

  // Index of the final byte of the field collected in a given state
  function automatic logic [2:0] field_last(input rx_state_t st, input int payload_bytes);
    logic [2:0] v_last;
    v_last = 3'd0;
    case (st)
      ST_DEST:    v_last = 3'(c_dest_bytes - 1);
      ST_SRC:     v_last = 3'(c_src_bytes - 1);
      ST_TYPE:    v_last = 3'(c_type_bytes - 1);
      ST_PAYLOAD: v_last = 3'(payload_bytes - 1);
      ST_FCS:     v_last = 3'(c_fcs_bytes - 1);
      default:    v_last = 3'd0;
    endcase
    return v_last;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_reception_if.sv
`default_nettype none
// ============================================================================
// Module  : frame_reception_if
// Brief   : Received byte stream plus decoded frame fields and status strobes.
// Revision: 1.0  initial release
// ============================================================================
interface frame_reception_if #(
  parameter int PAYLOAD_BYTES = 4
);

  logic [7:0]                 rx_in;
  logic                       rx_en;
  logic [47:0]                dest_addr;
  logic [47:0]                src_addr;
  logic [15:0]                eth_type;
  logic [8*PAYLOAD_BYTES-1:0] data_out;
  logic                       rx_done;
  logic                       crc_ok;
  logic                       addr_match;
  logic                       rx_err;

  // master drives the byte stream, slave is the parser
  modport master (
    output rx_in, rx_en,
    input  dest_addr, src_addr, eth_type, data_out,
    input  rx_done, crc_ok, addr_match, rx_err
  );

  modport slave (
    input  rx_in, rx_en,
    output dest_addr, src_addr, eth_type, data_out,
    output rx_done, crc_ok, addr_match, rx_err
  );

endinterface
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module  : crc32_d8
// Brief   : Combinational reflected CRC-32 update for one byte (LSB first).
// Revision: 1.0  initial release
// ============================================================================
module crc32_d8
  import frame_reception_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] w_acc;
    w_acc = crc_in ^ {24'd0, byte_in};
    for (int i = 0; i < 8; i++) begin
      w_acc = w_acc[0] ? ((w_acc >> 1) ^ c_crc32_poly) : (w_acc >> 1);
    end
    crc_out = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/frame_reception.sv
`default_nettype none
// ============================================================================
// Module  : frame_reception
// Brief   : Byte-wide Ethernet receive parser: strips preamble/SFD, extracts
//           dest/src/type/payload and checks the FCS.
// Revision: 1.0  initial release
// ============================================================================
module frame_reception
  import frame_reception_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 4,
  parameter int          PREAMBLE_MIN  = 1,
  parameter logic [47:0] MY_ADDR       = 48'h123456789ABC
) (
  input  logic             clk,
  input  logic             rst,
  frame_reception_if.slave bus,
  output logic [3:0]       state
);

  localparam int c_data_w = 8 * PAYLOAD_BYTES;

  rx_state_t           r_state;
  rx_state_t           w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic                w_crc_clr;
  logic                w_crc_en;
  logic [31:0]         r_crc;
  logic [31:0]         w_crc_upd;

  logic [47:0]         r_dest;
  logic [47:0]         r_src;
  logic [15:0]         r_type;
  logic [c_data_w-1:0] r_data;
  logic [c_data_w-1:0] w_data_shift;
  logic [31:0]         r_fcs;

  logic [47:0]         r_out_dest;
  logic [47:0]         r_out_src;
  logic [15:0]         r_out_type;
  logic [c_data_w-1:0] r_out_data;
  logic                r_done;
  logic                r_crc_ok;
  logic                r_addr_match;
  logic                r_err;

  crc32_d8 u_crc (
    .crc_in  (r_crc),
    .byte_in (bus.rx_in),
    .crc_out (w_crc_upd)
  );

  generate
    if (PAYLOAD_BYTES > 1) begin : g_data_wide
      assign w_data_shift = {r_data[c_data_w-9:0], bus.rx_in};
    end else begin : g_data_narrow
      assign w_data_shift = bus.rx_in;
    end
  endgenerate

  assign w_crc_en = bus.rx_en &&
                    (r_state inside {ST_DEST, ST_SRC, ST_TYPE, ST_PAYLOAD});

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_crc_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_en && (bus.rx_in == c_eth_preamble)) begin
          w_state_nxt = ST_PREAMBLE;
          w_cnt_nxt   = 3'd1;
        end
      end
      ST_PREAMBLE: begin
        if (!bus.rx_en) begin
          w_state_nxt = ST_ERROR;
          w_cnt_nxt   = 3'd0;
        end else if (bus.rx_in == c_eth_preamble) begin
          if (r_cnt != c_cnt_max) begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else if ((bus.rx_in == c_eth_sfd) && (int'(r_cnt) >= PREAMBLE_MIN)) begin
          w_state_nxt = ST_DEST;
          w_cnt_nxt   = 3'd0;
          w_crc_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_ERROR;
          w_cnt_nxt   = 3'd0;
        end
      end
      ST_DEST, ST_SRC, ST_TYPE, ST_PAYLOAD, ST_FCS: begin
        if (!bus.rx_en) begin
          w_state_nxt = ST_ERROR;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt == field_last(r_state, PAYLOAD_BYTES)) begin
          w_cnt_nxt = 3'd0;
          case (r_state)
            ST_DEST:    w_state_nxt = ST_SRC;
            ST_SRC:     w_state_nxt = ST_TYPE;
            ST_TYPE:    w_state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: w_state_nxt = ST_FCS;
            default:    w_state_nxt = ST_DONE;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = bus.rx_en ? ST_DRAIN : ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
      ST_ERROR, ST_DRAIN: begin
        if (!bus.rx_en) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_crc        <= c_crc32_init;
      r_dest       <= '0;
      r_src        <= '0;
      r_type       <= '0;
      r_data       <= '0;
      r_fcs        <= '0;
      r_out_dest   <= '0;
      r_out_src    <= '0;
      r_out_type   <= '0;
      r_out_data   <= '0;
      r_done       <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_addr_match <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;

      if (w_crc_clr) begin
        r_crc <= c_crc32_init;
      end else if (w_crc_en) begin
        r_crc <= w_crc_upd;
      end

      if (bus.rx_en) begin
        case (r_state)
          ST_DEST:    r_dest <= {r_dest[39:0], bus.rx_in};
          ST_SRC:     r_src  <= {r_src[39:0], bus.rx_in};
          ST_TYPE:    r_type <= {r_type[7:0], bus.rx_in};
          ST_PAYLOAD: r_data <= w_data_shift;
          // FCS arrives least-significant byte first
          ST_FCS:     r_fcs  <= {bus.rx_in, r_fcs[31:8]};
          default:    ;
        endcase
      end

      r_done <= (r_state == ST_DONE);
      r_err  <= (w_state_nxt == ST_ERROR) && (r_state != ST_ERROR);

      // Only a fully received frame ever reaches the output registers
      if (r_state == ST_DONE) begin
        r_out_dest   <= r_dest;
        r_out_src    <= r_src;
        r_out_type   <= r_type;
        r_out_data   <= r_data;
        r_crc_ok     <= (r_fcs == ~r_crc);
        r_addr_match <= (r_dest == MY_ADDR) || (r_dest == c_bcast_addr);
      end
    end
  end

  assign bus.dest_addr  = r_out_dest;
  assign bus.src_addr   = r_out_src;
  assign bus.eth_type   = r_out_type;
  assign bus.data_out   = r_out_data;
  assign bus.rx_done    = r_done;
  assign bus.crc_ok     = r_crc_ok;
  assign bus.addr_match = r_addr_match;
  assign bus.rx_err     = r_err;
  assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_frame_reception.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_reception
// Brief   : Self-checking bench for frame_reception against a byte-level model.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_reception;

  localparam int          PB = 4;
  localparam logic [47:0] MY = 48'h123456789ABC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state;

  frame_reception_if #(.PAYLOAD_BYTES(PB)) bus ();

  frame_reception #(
    .PAYLOAD_BYTES (PB),
    .PREAMBLE_MIN  (1),
    .MY_ADDR       (MY)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;

  logic [47:0] cap_dest, cap_src;
  logic [15:0] cap_type;
  logic [31:0] cap_data;
  logic        cap_crc_ok, cap_am;

  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) begin
      n_done++;
      cap_dest   = bus.dest_addr;
      cap_src    = bus.src_addr;
      cap_type   = bus.eth_type;
      cap_data   = bus.data_out;
      cap_crc_ok = bus.crc_ok;
      cap_am     = bus.addr_match;
    end
    if (bus.rx_err === 1'b1) n_err++;
    if (bus.rx_done === 1'b1 && bus.rx_err === 1'b1) n_both++;
  end

  // ---------------- reference model ----------------
  logic [7:0]  tx_q[$];
  int          hdr_off;
  logic [47:0] exp_dest, exp_src, prev_dest, prev_src;
  logic [15:0] exp_type, prev_type;
  logic [31:0] exp_data, prev_data;
  logic        exp_crc_ok, exp_am;

  function automatic logic [31:0] model_fcs(input int start, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = start; k < start + n; k++) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ tx_q[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t, input logic [31:0] p, input int pre_len);
    logic [31:0] c;
    tx_q.delete();
    repeat (pre_len) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    hdr_off = tx_q.size();
    for (int i = 5; i >= 0; i--) tx_q.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) tx_q.push_back(s[8*i +: 8]);
    for (int i = 1; i >= 0; i--) tx_q.push_back(t[8*i +: 8]);
    for (int i = PB-1; i >= 0; i--) tx_q.push_back(p[8*i +: 8]);
    c = model_fcs(hdr_off, 14 + PB);
    for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
  endtask

  // Expected decode of whatever bytes are currently in tx_q
  task automatic model_expect();
    logic [31:0] rx_fcs;
    exp_dest = '0; exp_src = '0; exp_type = '0; exp_data = '0; rx_fcs = '0;
    for (int i = 0; i < 6; i++)  exp_dest = (exp_dest << 8) | 48'(tx_q[hdr_off + i]);
    for (int i = 0; i < 6; i++)  exp_src  = (exp_src << 8)  | 48'(tx_q[hdr_off + 6 + i]);
    for (int i = 0; i < 2; i++)  exp_type = (exp_type << 8) | 16'(tx_q[hdr_off + 12 + i]);
    for (int i = 0; i < PB; i++) exp_data = (exp_data << 8) | 32'(tx_q[hdr_off + 14 + i]);
    for (int i = 0; i < 4; i++)  rx_fcs   = rx_fcs | (32'(tx_q[hdr_off + 14 + PB + i]) << (8*i));
    exp_crc_ok = (model_fcs(hdr_off, 14 + PB) == rx_fcs);
    exp_am     = (exp_dest == MY) || (exp_dest == 48'hFFFFFFFFFFFF);
  endtask

  task automatic remember_prev();
    prev_dest = exp_dest; prev_src = exp_src; prev_type = exp_type; prev_data = exp_data;
  endtask

  // Drives the first n bytes of tx_q (all if n<0), then trail random bytes, then drops rx_en
  task automatic send(input int n, input int trail);
    int cnt;
    cnt = (n < 0) ? tx_q.size() : n;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk); bus.rx_in = tx_q[i]; bus.rx_en = 1'b1;
    end
    for (int i = 0; i < trail; i++) begin
      @(negedge clk); bus.rx_in = 8'($urandom); bus.rx_en = 1'b1;
    end
    @(negedge clk); bus.rx_en = 1'b0; bus.rx_in = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL reset state: got %0d want 0", state); end
    n_cmp++; if (bus.rx_done !== 1'b0 || bus.rx_err !== 1'b0) begin n_bad++;
      $display("FAIL reset strobes: got done=%b err=%b want 0/0", bus.rx_done, bus.rx_err); end
    n_cmp++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.data_out} !== '0) begin n_bad++;
      $display("FAIL reset fields: got %h %h %h %h want all 0", bus.dest_addr, bus.src_addr, bus.eth_type, bus.data_out); end
    n_cmp++; if (bus.crc_ok !== 1'b0 || bus.addr_match !== 1'b0) begin n_bad++;
      $display("FAIL reset flags: got crc_ok=%b am=%b want 0/0", bus.crc_ok, bus.addr_match); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_golden();
    build_frame(48'h123456789ABC, 48'hABCDEF123456, 16'h0800, 32'h11223344, 7);
    model_expect();
    send(-1, 0);
    // now in the cycle after the last FCS byte was sampled
    n_cmp++; if (bus.rx_done !== 1'b0 || state !== 4'd7) begin n_bad++;
      $display("FAIL golden pre-done: got done=%b state=%0d want 0/7", bus.rx_done, state); end
    @(negedge clk);
    n_cmp++; if (bus.rx_done !== 1'b1) begin n_bad++; $display("FAIL golden latency: got done=%b want 1", bus.rx_done); end
    n_cmp++; if (bus.crc_ok !== 1'b1 || bus.addr_match !== 1'b1) begin n_bad++;
      $display("FAIL golden flags: got crc_ok=%b am=%b want 1/1", bus.crc_ok, bus.addr_match); end
    n_cmp++; if (bus.dest_addr !== 48'h123456789ABC || bus.src_addr !== 48'hABCDEF123456) begin n_bad++;
      $display("FAIL golden addr: got %h/%h want 123456789abc/abcdef123456", bus.dest_addr, bus.src_addr); end
    n_cmp++; if (bus.eth_type !== 16'h0800 || bus.data_out !== 32'h11223344) begin n_bad++;
      $display("FAIL golden type/data: got %h/%h want 0800/11223344", bus.eth_type, bus.data_out); end
    @(negedge clk);
    n_cmp++; if (bus.rx_done !== 1'b0) begin n_bad++; $display("FAIL golden pulse width: got done=%b want 0", bus.rx_done); end
    remember_prev();
  endtask

  task automatic test_bad_crc();
    int d0;
    build_frame(48'h123456789ABC, 48'hABCDEF123456, 16'h0800, 32'h11223344, 7);
    tx_q[hdr_off + 14 + 2] = 8'h32;
    model_expect();
    d0 = n_done;
    send(-1, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL badcrc done count: got %0d want 1", n_done - d0); end
    n_cmp++; if (cap_crc_ok !== 1'b0) begin n_bad++; $display("FAIL badcrc crc_ok: got %b want 0", cap_crc_ok); end
    n_cmp++; if (cap_data !== 32'h11223244) begin n_bad++; $display("FAIL badcrc data: got %h want 11223244", cap_data); end
    remember_prev();
  endtask

  task automatic test_abort();
    int d0, e0;
    build_frame(48'h0A0B0C0D0E0F, 48'h665544332211, 16'h86DD, 32'hCAFEF00D, 3);
    d0 = n_done; e0 = n_err;
    send(hdr_off + 6 + 3, 0);
    @(negedge clk);
    n_cmp++; if (bus.rx_err !== 1'b1 || state !== 4'd8) begin n_bad++;
      $display("FAIL abort entry: got err=%b state=%0d want 1/8", bus.rx_err, state); end
    @(negedge clk);
    n_cmp++; if (bus.rx_err !== 1'b0 || state !== 4'd0) begin n_bad++;
      $display("FAIL abort exit: got err=%b state=%0d want 0/0", bus.rx_err, state); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 0 || n_err - e0 !== 1) begin n_bad++;
      $display("FAIL abort counts: got done=%0d err=%0d want 0/1", n_done - d0, n_err - e0); end
    n_cmp++; if (bus.dest_addr !== prev_dest || bus.src_addr !== prev_src ||
                 bus.eth_type !== prev_type || bus.data_out !== prev_data) begin n_bad++;
      $display("FAIL abort hold: got %h %h %h %h want %h %h %h %h", bus.dest_addr, bus.src_addr,
               bus.eth_type, bus.data_out, prev_dest, prev_src, prev_type, prev_data); end
  endtask

  task automatic test_bad_preamble();
    int d0, e0;
    tx_q.delete();
    tx_q.push_back(8'h55); tx_q.push_back(8'h55); tx_q.push_back(8'h57);
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    e0 = n_err;
    send(-1, 0);
    @(negedge clk);
    n_cmp++; if (n_err - e0 !== 1 || state !== 4'd0) begin n_bad++;
      $display("FAIL preamble err: got errs=%0d state=%0d want 1/0", n_err - e0, state); end
    build_frame(MY, 48'h0000AA55AA55, 16'h0806, $urandom, 2);
    model_expect();
    d0 = n_done; e0 = n_err;
    send(-1, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin n_bad++;
      $display("FAIL preamble recover counts: got done=%0d err=%0d want 1/0", n_done - d0, n_err - e0); end
    n_cmp++; if (cap_crc_ok !== 1'b1 || cap_data !== exp_data) begin n_bad++;
      $display("FAIL preamble recover: got crc_ok=%b data=%h want 1/%h", cap_crc_ok, cap_data, exp_data); end
    remember_prev();
  endtask

  task automatic test_addr_match();
    build_frame(48'hFFFFFFFFFFFF, 48'h010203040506, 16'h0800, $urandom, 1);
    model_expect();
    send(-1, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (cap_am !== 1'b1 || cap_crc_ok !== 1'b1) begin n_bad++;
      $display("FAIL bcast match: got am=%b crc_ok=%b want 1/1", cap_am, cap_crc_ok); end
    build_frame(48'h020000000001, 48'h010203040506, 16'h0800, $urandom, 4);
    model_expect();
    send(-1, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (cap_am !== 1'b0 || cap_crc_ok !== 1'b1) begin n_bad++;
      $display("FAIL other dest: got am=%b crc_ok=%b want 0/1", cap_am, cap_crc_ok); end
    n_cmp++; if (cap_dest !== 48'h020000000001) begin n_bad++;
      $display("FAIL other dest addr: got %h want 020000000001", cap_dest); end
    remember_prev();
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    build_frame(MY, 48'hABCDEF123456, 16'h0800, 32'h11223344, 7);
    for (int i = 0; i < hdr_off + 14 + 2; i++) begin
      @(negedge clk); bus.rx_in = tx_q[i]; bus.rx_en = 1'b1;
    end
    @(negedge clk); rst = 1'b1; bus.rx_in = tx_q[hdr_off + 16]; bus.rx_en = 1'b1;
    e0 = n_err;
    @(negedge clk);
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL midrst state: got %0d want 0", state); end
    n_cmp++; if ({bus.dest_addr, bus.src_addr, bus.eth_type, bus.data_out, bus.crc_ok, bus.addr_match,
                  bus.rx_done, bus.rx_err} !== '0) begin n_bad++;
      $display("FAIL midrst outputs: got %h %h %h %h ok=%b am=%b done=%b err=%b want all 0", bus.dest_addr,
               bus.src_addr, bus.eth_type, bus.data_out, bus.crc_ok, bus.addr_match, bus.rx_done, bus.rx_err); end
    rst = 1'b0; bus.rx_en = 1'b0; bus.rx_in = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL midrst rx_err: got %0d pulses want 0", n_err - e0); end
    model_expect();
    d0 = n_done;
    send(-1, 0);
    repeat (3) @(negedge clk);
    n_cmp++; if (n_done - d0 !== 1 || cap_crc_ok !== 1'b1 || cap_data !== exp_data) begin n_bad++;
      $display("FAIL midrst next frame: got done=%0d crc_ok=%b data=%h want 1/1/%h",
               n_done - d0, cap_crc_ok, cap_data, exp_data); end
    remember_prev();
  endtask

  task automatic test_random();
    int d0, e0, trail, sel, idx;
    logic [63:0] r_d, r_s;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 3);
      r_d = {$urandom, $urandom};
      r_s = {$urandom, $urandom};
      if (sel == 0) r_d[47:0] = MY;
      else if (sel == 1) r_d[47:0] = 48'hFFFFFFFFFFFF;
      build_frame(r_d[47:0], r_s[47:0], 16'($urandom), $urandom, $urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(hdr_off, tx_q.size() - 1);
        tx_q[idx] = tx_q[idx] ^ (8'h01 << $urandom_range(0, 7));
      end
      model_expect();
      trail = $urandom_range(0, 3);
      d0 = n_done; e0 = n_err;
      send(-1, trail);
      repeat ($urandom_range(2, 4)) @(negedge clk);
      n_cmp++; if (n_done - d0 !== 1 || n_err - e0 !== 0) begin n_bad++;
        $display("FAIL rnd%0d counts: got done=%0d err=%0d want 1/0", it, n_done - d0, n_err - e0); end
      n_cmp++; if (cap_dest !== exp_dest || cap_src !== exp_src) begin n_bad++;
        $display("FAIL rnd%0d addr: got %h/%h want %h/%h", it, cap_dest, cap_src, exp_dest, exp_src); end
      n_cmp++; if (cap_type !== exp_type || cap_data !== exp_data) begin n_bad++;
        $display("FAIL rnd%0d type/data: got %h/%h want %h/%h", it, cap_type, cap_data, exp_type, exp_data); end
      n_cmp++; if (cap_crc_ok !== exp_crc_ok) begin n_bad++;
        $display("FAIL rnd%0d crc_ok: got %b want %b", it, cap_crc_ok, exp_crc_ok); end
      n_cmp++; if (cap_am !== exp_am) begin n_bad++;
        $display("FAIL rnd%0d addr_match: got %b want %b", it, cap_am, exp_am); end
    end
    n_cmp++; if (n_both !== 0) begin n_bad++; $display("FAIL done/err overlap: got %0d cycles want 0", n_both); end
  endtask

  initial begin
    bus.rx_in = 8'h00;
    bus.rx_en = 1'b0;
    test_reset();
    test_golden();
    test_bad_crc();
    test_abort();
    test_bad_preamble();
    test_addr_match();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
